// File: rtl/y_pack_pkg.sv
// Shared sizing helpers and the FIFO entry layout for the y-tile row packer.
package y_pack_pkg;

  localparam int Y_PACK_DATA_W = 256;

  // Canonical FIFO entry at the default word width; the top rebuilds it at its own DATA_W.
  typedef struct packed {
    logic                     last;
    logic [Y_PACK_DATA_W-1:0] data;
  } y_pack_entry_t;

  function automatic int tiles_per_word(input int data_w, input int tile_size,
                                        input int data_width);
    return data_w / (tile_size * data_width);
  endfunction

  function automatic int words_per_row(input int d, input int data_width, input int data_w);
    return (d * data_width) / data_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/y_pack_skid_fifo.sv
// Two-entry valid/ready FIFO; push_ready_o and pop_valid_o come straight from registered state.
module y_pack_skid_fifo
  import y_pack_pkg::*;
#(
  parameter int ENTRY_W = 257
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  output logic               push_ready_o,
  output logic               pop_valid_o,
  input  logic               pop_ready_i,
  output logic [ENTRY_W-1:0] pop_data_o,
  output logic [1:0]         count_o
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  assign do_push = push_i && push_ready_o;
  assign do_pop  = pop_ready_i && pop_valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = !wr_ptr_q;
    if (do_pop)  rd_ptr_d = !rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only: emptiness is tracked by count_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/y_tile_row_packer.sv
// Packs TILE_SIZE-lane y tiles into DATA_W words, marks row ends with TLAST, counts delivered rows.
module y_tile_row_packer
  import y_pack_pkg::*;
#(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_W     = 256,
  parameter int D          = 256,
  parameter int ROWCNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         y_axis_TVALID,
  output logic                         y_axis_TREADY,
  input  logic signed [DATA_WIDTH-1:0] y_axis_TDATA [TILE_SIZE],
  output logic                         m_axis_TVALID,
  input  logic                         m_axis_TREADY,
  output logic [DATA_W-1:0]            m_axis_TDATA,
  output logic                         m_axis_TLAST,
  output logic [ROWCNT_W-1:0]          rows_done,
  output logic                         busy
);

  localparam int TILE_W         = TILE_SIZE * DATA_WIDTH;
  localparam int TILES_PER_WORD = tiles_per_word(DATA_W, TILE_SIZE, DATA_WIDTH);
  localparam int WORDS_PER_ROW  = words_per_row(D, DATA_WIDTH, DATA_W);
  localparam int TIDX_W         = idx_width(TILES_PER_WORD);
  localparam int WIDX_W         = idx_width(WORDS_PER_ROW);

  localparam logic [TIDX_W-1:0] TIDX_LAST = TIDX_W'(TILES_PER_WORD - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS_PER_ROW - 1);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  if (DATA_W % TILE_W != 0) begin : g_chk_word
    $error("y_tile_row_packer: DATA_W must be a multiple of TILE_SIZE*DATA_WIDTH");
  end
  if ((D * DATA_WIDTH) % DATA_W != 0) begin : g_chk_row
    $error("y_tile_row_packer: D*DATA_WIDTH must be a multiple of DATA_W");
  end

  logic                rst_q;
  logic [TIDX_W-1:0]   tile_idx_q, tile_idx_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [ROWCNT_W-1:0] rows_q, rows_d;
  logic [DATA_W-1:0]   word_q;

  logic [TILE_W-1:0]   tile_bits;
  logic [DATA_W-1:0]   assembled;
  logic                accept, word_done, m_fire;
  logic                fifo_push_ready, fifo_valid;
  logic [1:0]          fifo_count;
  entry_t              push_entry, head;
  logic [ENTRY_W-1:0]  fifo_out;

  always_comb begin
    tile_bits = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      tile_bits[i*DATA_WIDTH +: DATA_WIDTH] = y_axis_TDATA[i];
    end
  end

  // Ready looks only at registered state: a completing tile needs a free FIFO slot, others never stall.
  assign y_axis_TREADY = !rst_q && (fifo_push_ready || (tile_idx_q != TIDX_LAST));
  assign accept        = y_axis_TVALID && y_axis_TREADY;
  assign word_done     = accept && (tile_idx_q == TIDX_LAST);
  assign m_fire        = fifo_valid && m_axis_TREADY;

  // The completing tile bypasses word_q so the full word enters the FIFO on the same edge.
  always_comb begin
    assembled = word_q;
    assembled[(TILES_PER_WORD-1)*TILE_W +: TILE_W] = tile_bits;
  end

  assign push_entry.last = (word_idx_q == WIDX_LAST);
  assign push_entry.data = assembled;

  always_comb begin
    tile_idx_d = tile_idx_q;
    word_idx_d = word_idx_q;
    rows_d     = rows_q;
    if (accept) begin
      tile_idx_d = (tile_idx_q == TIDX_LAST) ? '0 : tile_idx_q + 1'b1;
    end
    if (word_done) begin
      word_idx_d = (word_idx_q == WIDX_LAST) ? '0 : word_idx_q + 1'b1;
    end
    if (m_fire && head.last) begin
      rows_d = rows_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      tile_idx_q <= '0;
      word_idx_q <= '0;
      rows_q     <= '0;
    end else begin
      tile_idx_q <= tile_idx_d;
      word_idx_q <= word_idx_d;
      rows_q     <= rows_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) word_q[int'(tile_idx_q)*TILE_W +: TILE_W] <= tile_bits;
  end

  y_pack_skid_fifo #(
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (word_done),
    .push_data_i  (push_entry),
    .push_ready_o (fifo_push_ready),
    .pop_valid_o  (fifo_valid),
    .pop_ready_i  (m_axis_TREADY),
    .pop_data_o   (fifo_out),
    .count_o      (fifo_count)
  );

  assign head = fifo_out;

  // Unreset FIFO storage is masked so an empty stream always shows zero data and TLAST.
  assign m_axis_TVALID = fifo_valid;
  assign m_axis_TDATA  = fifo_valid ? head.data : '0;
  assign m_axis_TLAST  = fifo_valid && head.last;
  assign rows_done     = rows_q;
  assign busy          = (tile_idx_q != '0) || (fifo_count != 2'd0);

endmodule

// File: tb/tb_y_tile_row_packer.sv
// Scoreboard bench for y_tile_row_packer: expected words are queued as tiles go in, popped on output.
module tb_y_tile_row_packer;

  localparam int TS     = 4;
  localparam int DW     = 16;
  localparam int DATA_W = 256;
  localparam int D      = 256;
  localparam int RW     = 16;
  localparam int TPW    = DATA_W / (TS * DW);
  localparam int WPR    = D * DW / DATA_W;
  localparam int LANES  = DATA_W / DW;
  localparam int TPR    = D / TS;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 y_axis_TVALID = 1'b0;
  logic                 y_axis_TREADY;
  logic signed [DW-1:0] y_axis_TDATA [TS];
  logic                 m_axis_TVALID;
  logic                 m_axis_TREADY = 1'b0;
  logic [DATA_W-1:0]    m_axis_TDATA;
  logic                 m_axis_TLAST;
  logic [RW-1:0]        rows_done;
  logic                 busy;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          rdy_pct = 100;
  int          tile_mod = 0;
  logic        stall_prev = 1'b0;
  logic [DATA_W:0] prev_out = '0;

  always #5 clk = ~clk;

  y_tile_row_packer #(
    .TILE_SIZE  (TS),
    .DATA_WIDTH (DW),
    .DATA_W     (DATA_W),
    .D          (D),
    .ROWCNT_W   (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .y_axis_TVALID (y_axis_TVALID),
    .y_axis_TREADY (y_axis_TREADY),
    .y_axis_TDATA  (y_axis_TDATA),
    .m_axis_TVALID (m_axis_TVALID),
    .m_axis_TREADY (m_axis_TREADY),
    .m_axis_TDATA  (m_axis_TDATA),
    .m_axis_TLAST  (m_axis_TLAST),
    .rows_done     (rows_done),
    .busy          (busy)
  );

  function automatic logic signed [DW-1:0] elem(input int base, input int idx, input bit neg);
    int v;
    v = base + idx;
    return neg ? DW'(-v - 1) : DW'(v);
  endfunction

  function automatic exp_t exp_word(input int base, input int w, input bit neg);
    exp_t e;
    e.last = (w == WPR - 1);
    e.data = '0;
    for (int j = 0; j < LANES; j++) e.data[j*DW +: DW] = elem(base, w * LANES + j, neg);
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_TREADY = (int'($urandom_range(99)) < rdy_pct);
    end
  end

  // Output monitor: handshakes are judged at the negedge preceding the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (m_axis_TVALID !== 1'b1 || {m_axis_TLAST, m_axis_TDATA} !== prev_out) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b last=%b data=%h, required valid=1 last/data=%h",
                   m_axis_TVALID, m_axis_TLAST, m_axis_TDATA, prev_out);
        end
      end
      if (m_axis_TVALID === 1'b1 && m_axis_TREADY === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got last=%b data=%h, required no word",
                   m_axis_TLAST, m_axis_TDATA);
        end else begin
          mon_e = sb_q.pop_front();
          if (m_axis_TLAST !== mon_e.last || m_axis_TDATA !== mon_e.data) begin
            errors++;
            $display("FAIL word: got last=%b data=%h, required last=%b data=%h",
                     m_axis_TLAST, m_axis_TDATA, mon_e.last, mon_e.data);
          end
        end
      end
      stall_prev = (m_axis_TVALID === 1'b1) && (m_axis_TREADY !== 1'b1);
      prev_out   = {m_axis_TLAST, m_axis_TDATA};
    end
  end

  task automatic drive_tiles(input int base, input int first, input int n, input int vld_pct,
                             input bit neg);
    for (int t = first; t < first + n; t++) begin
      int   budget;
      logic acc;
      while (int'($urandom_range(99)) >= vld_pct) begin
        y_axis_TVALID = 1'b0;
        @(posedge clk);
        #1;
      end
      y_axis_TVALID = 1'b1;
      for (int i = 0; i < TS; i++) y_axis_TDATA[i] = elem(base, t * TS + i, neg);
      budget = 0;
      acc    = 1'b0;
      do begin
        @(negedge clk);
        acc = (y_axis_TREADY === 1'b1);
        @(posedge clk);
        #1;
        budget++;
      end while (!acc && budget < 2000);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: tile %0d not accepted after %0d cycles, required accept",
                 t, budget);
        y_axis_TVALID = 1'b0;
        return;
      end
      tile_mod = (t + 1) % TPW;
      if (t % TPW == TPW - 1) sb_q.push_back(exp_word(base, t / TPW, neg));
    end
    y_axis_TVALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (!(sb_q.size() == 0 && m_axis_TVALID === 1'b0) && budget < 5000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d words pending, valid=%b, required empty", name, sb_q.size(),
               m_axis_TVALID);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst           = 1'b1;
    y_axis_TVALID = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    tile_mod = 0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    y_axis_TVALID = 1'b1;
    for (int i = 0; i < TS; i++) y_axis_TDATA[i] = DW'(i + 100);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (y_axis_TREADY !== 1'b0 || m_axis_TVALID !== 1'b0 || rows_done !== '0 ||
          busy !== 1'b0 || m_axis_TDATA !== '0 || m_axis_TLAST !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got tready=%b mvalid=%b rows=%0d busy=%b last=%b, required 0s",
                 y_axis_TREADY, m_axis_TVALID, rows_done, busy, m_axis_TLAST);
      end
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    y_axis_TVALID = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (y_axis_TREADY !== 1'b1 || busy !== 1'b0 || m_axis_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got tready=%b busy=%b mvalid=%b, required 1 0 0",
               y_axis_TREADY, busy, m_axis_TVALID);
    end
  endtask

  task automatic test_single_word();
    logic [DATA_W-1:0] want;
    rdy_pct = 100;
    drive_tiles(1, 0, 3, 100, 1'b0);
    checks++;
    if (m_axis_TVALID !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_partial: got mvalid=%b busy=%b, required 0 1", m_axis_TVALID, busy);
    end
    drive_tiles(1, 3, 1, 100, 1'b0);
    want = '0;
    for (int j = 0; j < LANES; j++) want[j*DW +: DW] = DW'(j + 1);
    checks++;
    if (m_axis_TVALID !== 1'b1 || m_axis_TLAST !== 1'b0 || m_axis_TDATA !== want) begin
      errors++;
      $display("FAIL single_word: got valid=%b last=%b data=%h, required 1 0 %h",
               m_axis_TVALID, m_axis_TLAST, m_axis_TDATA, want);
    end
    wait_drain("single");
    checks++;
    if (rows_done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got rows=%0d busy=%b, required 0 0", rows_done, busy);
    end
    do_reset(2);
  endtask

  task automatic test_full_rows();
    rdy_pct = 100;
    for (int r = 0; r < 2; r++) begin
      drive_tiles(r * 256, 0, TPR, 100, 1'b0);
      wait_drain("full_row");
      checks++;
      if (rows_done !== RW'(r + 1) || busy !== 1'b0) begin
        errors++;
        $display("FAIL full_rows_done: got rows=%0d busy=%b, required %0d 0", rows_done, busy,
                 r + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    rdy_pct       = 0;
    m_axis_TREADY = 1'b0;
    fork
      drive_tiles(512, 0, TPR, 100, 1'b0);
      begin
        repeat (20) begin
          @(negedge clk);
          checks++;
          if (y_axis_TREADY === 1'b0 && tile_mod != TPW - 1) begin
            errors++;
            $display("FAIL bp_ready_drop: got tready=0 at tile slot %0d, required slot %0d",
                     tile_mod, TPW - 1);
          end
        end
        checks++;
        if (y_axis_TREADY !== 1'b0 || m_axis_TVALID !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL bp_full: got tready=%b mvalid=%b busy=%b, required 0 1 1",
                   y_axis_TREADY, m_axis_TVALID, busy);
        end
        rdy_pct = 100;
      end
    join
    wait_drain("bp");
    checks++;
    if (rows_done !== RW'(3)) begin
      errors++;
      $display("FAIL bp_rows: got rows=%0d, required 3", rows_done);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    rdy_pct = 30;
    for (int r = 0; r < 8; r++) drive_tiles(r * 256, 0, TPR, 50, bit'(r % 2));
    wait_drain("random");
    rdy_pct = 100;
    checks++;
    if (rows_done !== RW'(8) || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_rows: got rows=%0d busy=%b, required 8 0", rows_done, busy);
    end
  endtask

  task automatic test_reset_mid_row();
    rdy_pct       = 0;
    m_axis_TREADY = 1'b0;
    drive_tiles(0, 0, 10, 100, 1'b0);
    checks++;
    if (m_axis_TVALID !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_before: got mvalid=%b busy=%b, required 1 1", m_axis_TVALID, busy);
    end
    do_reset(1);
    checks++;
    if (m_axis_TVALID !== 1'b0 || busy !== 1'b0 || rows_done !== '0 || m_axis_TDATA !== '0) begin
      errors++;
      $display("FAIL mid_reset: got mvalid=%b busy=%b rows=%0d, required 0 0 0",
               m_axis_TVALID, busy, rows_done);
    end
    rdy_pct = 100;
    drive_tiles(3000, 0, TPR, 100, 1'b1);
    wait_drain("mid");
    checks++;
    if (rows_done !== RW'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_row_after: got rows=%0d busy=%b, required 1 0", rows_done, busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < TS; i++) y_axis_TDATA[i] = '0;
    test_reset();
    test_single_word();
    test_full_rows();
    test_backpressure();
    test_random();
    test_reset_mid_row();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending words, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
